mantissa_shift_sequencer: RTL and testbench
===========================================

Name: mantissa_shift_sequencer

Overview:
- Sequential controller on the command side of the FP mantissa shift datapath in the OoO core.
- Accepts a 24-bit mantissa and either normalizes it (left shift until bit 23 = 1) or aligns it (right shift by a requested amount), one position per clock.
- Reports the shift count, a sticky bit built from bits shifted out of the LSB end, and a zero flag.
- Sits between the FP add/sub exponent-compare logic and the rounding stage; uses a start/busy/done handshake.

Parameters:
- WIDTH, 24, mantissa width in bits.
- CNT_W, 5, width of the shift-amount and shift-count fields.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- mode  input  1  0 = normalize (left), 1 = align (right).
- mant_in  input  WIDTH  mantissa captured on an accepted start.
- shamt_in  input  CNT_W  right-shift amount for align mode (0..31); ignored in normalize mode.
- mant_out  output  WIDTH  working/result mantissa register.
- shift_count  output  CNT_W  positions shifted so far / final count.
- sticky  output  1  OR of all 1 bits shifted out of bit 0 (align mode only).
- zero  output  1  result mantissa is all zeros.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- Reset (async, active-high): state=IDLE; mant_out=0, shift_count=0, sticky=0, zero=0, busy=0, done=0. Reset mid-operation aborts immediately with no partial result.
- FSM states: IDLE, NORM, ALIGN, DONE.
- Start acceptance: start is accepted at an edge where state is IDLE or DONE (busy=0).
  - On accept: mant_out<=mant_in, shift_count<=0, sticky<=0, zero<=0.
  - Load an internal remaining counter <= shamt_in.
  - Next state is NORM if mode=0, ALIGN if mode=1.
  - start is ignored while busy=1.
- busy=1 exactly while the state is NORM or ALIGN.
- NORM, each edge:
  - mant_out==0: zero<=1, go to DONE.
  - else if mant_out[WIDTH-1]==1: go to DONE.
  - else: mant_out<=mant_out<<1 (0 fill), shift_count++.
- ALIGN, each edge:
  - remaining==0: zero<=(mant_out==0), go to DONE.
  - else: mant_out<=mant_out>>1 (0 fill into the MSB), sticky<=sticky|mant_out[0], shift_count++, remaining--.
- DONE: done=1 for exactly one cycle; all outputs hold. Next edge goes to IDLE, or to NORM/ALIGN if start is asserted (back-to-back allowed).
- Outputs hold their values in IDLE until the next accepted start.
- Latency, counted from the edge that accepts start:
  - normalize with k leading zeros: done high after k+1 edges (k ≤ 23);
  - zero input: done after 1 edge;
  - align with shamt s: done after s+1 edges.
- Width rules:
  - shift_count never exceeds 23 in NORM, and never exceeds 31 in ALIGN (no wrap).
  - shamt ≥ 24 drives mant_out to 0 and sets sticky to the OR of all input bits.
- Simultaneous start and done: the new operation wins; done still pulses for the finished operation in that cycle.

Optional Feature:
- Macro: NORM_NIBBLE_EN.
- Defined: in NORM, when mant_out[WIDTH-1:WIDTH-4]==0 and mant_out!=0, shift left by 4 and add 4 to shift_count in one cycle; otherwise use single-bit steps.
  - Normalize latency becomes floor(k/4)+(k mod 4)+1 edges.
  - ALIGN is unchanged.
- Undefined: 1 bit per cycle only, exactly as above.

Test Plan:
- Normalize mant_in=0x000123 -> mant_out=0x918000, shift_count=15, zero=0, sticky=0, done 16 edges after start (7 edges with NORM_NIBBLE_EN).
- Normalize mant_in=0x000000 -> zero=1, shift_count=0, mant_out=0, done 1 edge after start.
- Align mant_in=0x800001, shamt_in=4 -> mant_out=0x080000, sticky=1, shift_count=4, done after 5 edges. Then mant_in=0xFFFFFF, shamt_in=0 -> unchanged, sticky=0, done after 1 edge.
- Align mant_in=0xABCDEF, shamt_in=31 -> mant_out=0, sticky=1, zero=1, shift_count=31, done after 32 edges. A start pulse with different data mid-run is ignored.
- Align mant_in=0x123456, shamt_in=20; assert reset 5 cycles in -> all outputs 0 asynchronously, busy=0. A new normalize of 0x400000 after release -> 0x800000, count 1.
- Back-to-back: start held high through the DONE cycle of a normalize of 0x800000 -> done pulses, the second operation starts with no IDLE cycle, and busy is high the following cycle.

Source files
------------

// File: rtl/mantissa_shift_sequencer.sv
// ---------------------------------------------------------------------------
// mantissa_shift_sequencer
//
// Purpose:
//   Command-side sequencer for the FP mantissa shift datapath. It takes a
//   WIDTH-bit mantissa and processes it one step per clock in one of two modes:
//     - normalize: shift left until the MSB is set.
//     - align:     shift right by a requested amount. Bits shifted out of
//                  bit 0 are ORed into the sticky bit.
//   It reports the final mantissa, the shift count, the sticky bit and a zero
//   flag. The handshake is start/busy/done.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request pulse, only sampled while busy=0
//   mode         0 = normalize (left), 1 = align (right)
//   mant_in      mantissa captured on an accepted start
//   shamt_in     right-shift amount for align mode (ignored when normalizing)
//   mant_out     working/result mantissa
//   shift_count  positions shifted so far / final count
//   sticky       OR of all 1 bits shifted out of bit 0 (align only)
//   zero         result mantissa is all zeros
//   busy         operation in progress (NORM or ALIGN state)
//   done         one-cycle pulse, result valid
//
// Optional build macro:
//   NORM_NIBBLE_EN - when defined, normalize moves 4 positions in one cycle
//                    while the top nibble is zero and the mantissa is non-zero.
// ---------------------------------------------------------------------------
module mantissa_shift_sequencer #(
   parameter int WIDTH = 24,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] mant_in,
   input  logic [CNT_W-1:0] shamt_in,
   output logic [WIDTH-1:0] mant_out,
   output logic [CNT_W-1:0] shift_count,
   output logic             sticky,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ALIGN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mant_q, mant_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             sticky_q, sticky_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next-state and datapath logic. A start in DONE is accepted the same way
   // as in IDLE, so back-to-back operations skip the IDLE cycle.
   always_comb begin
      state_d     = state_q;
      mant_d      = mant_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      sticky_d    = sticky_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mant_d      = mant_in;
               count_d     = '0;
               sticky_d    = 1'b0;
               zero_d      = 1'b0;
               remaining_d = shamt_in;
               state_d     = mode ? ALIGN : NORM;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         // A zero mantissa can never be normalized, so test it first.
         NORM: begin
            if (mant_q == '0) begin
               zero_d  = 1'b1;
               state_d = DONE;
            end else if (mant_q[WIDTH-1]) begin
               state_d = DONE;
            end
`ifdef NORM_NIBBLE_EN
            else if (mant_q[WIDTH-1 -: 4] == 4'd0) begin
               mant_d  = mant_q << 4;
               count_d = count_q + CNT_W'(4);
            end
`endif
            else begin
               mant_d  = mant_q << 1;
               count_d = count_q + CNT_W'(1);
            end
         end

         // Once the mantissa is empty, the remaining steps shift in zeros.
         // They still count and still leave sticky unchanged.
         ALIGN: begin
            if (remaining_q == '0) begin
               zero_d  = (mant_q == '0);
               state_d = DONE;
            end else begin
               mant_d      = mant_q >> 1;
               sticky_d    = sticky_q | mant_q[0];
               count_d     = count_q + CNT_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == NORM) || (state_d == ALIGN);
      done_d = (state_d == DONE);
   end

   // Every flop of the block, including the status outputs, so that busy and
   // done change on the same edge as the state itself.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mant_q      <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         sticky_q    <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mant_q      <= mant_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         sticky_q    <= sticky_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mant_out    = mant_q;
   assign shift_count = count_q;
   assign sticky      = sticky_q;
   assign zero        = zero_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_mantissa_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mantissa_shift_sequencer
//
// Purpose:
//   Directed test of mantissa_shift_sequencer. Each issued operation pushes
//   its hand-computed result into a queue. A monitor pops that result on every
//   done pulse and compares it, including the latency from the accepting edge.
//
// Build macro:
//   NORM_NIBBLE_EN - when defined, the expected normalize latencies follow the
//                    nibble-step variant of the design.
// ---------------------------------------------------------------------------
module tb_mantissa_shift_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic        mode;
   logic [23:0] mant_in;
   logic [4:0]  shamt_in;
   logic [23:0] mant_out;
   logic [4:0]  shift_count;
   logic        sticky;
   logic        zero;
   logic        busy;
   logic        done;

   typedef struct {
      string       name;
      logic [23:0] mant;
      logic [4:0]  count;
      logic        sticky;
      logic        zero;
      int          latency;
      int          acceptEdge;
   } exp_t;

   exp_t sbQueue[$];
   exp_t monExp;
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   logic prevDone = 1'b0;

`ifdef NORM_NIBBLE_EN
   localparam int LatNorm123 = 7;
`else
   localparam int LatNorm123 = 16;
`endif

   mantissa_shift_sequencer #(.WIDTH(24), .CNT_W(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .mant_in     (mant_in),
      .shamt_in    (shamt_in),
      .mant_out    (mant_out),
      .shift_count (shift_count),
      .sticky      (sticky),
      .zero        (zero),
      .busy        (busy),
      .done        (done)
   );

   // Free-running clock with a 10-time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count rising edges. The monitor uses this count to measure latency.
   always @(posedge clock) cycle <= cycle + 1;

   // Every comparison in the bench goes through this task.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one start pulse. When pushExp is set, the expected result is also
   // queued. The accepting edge is the next rising edge.
   task automatic applyStimulus(input string name, input logic m, input logic [23:0] mant,
                                input logic [4:0] sh, input logic pushExp,
                                input logic [23:0] eMant, input logic [4:0] eCnt,
                                input logic eSticky, input logic eZero, input int eLat);
      exp_t t;
      @(negedge clock);
      start    = 1'b1;
      mode     = m;
      mant_in  = mant;
      shamt_in = sh;
      if (pushExp) begin
         t.name       = name;
         t.mant       = eMant;
         t.count      = eCnt;
         t.sticky     = eSticky;
         t.zero       = eZero;
         t.latency    = eLat;
         t.acceptEdge = cycle + 1;
         sbQueue.push_back(t);
      end
      @(negedge clock);
      start = 1'b0;
      checkOutput({name, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   // Wait until every queued result has been checked and the DUT is idle.
   // The wait is bounded so that a hung DUT still reaches the summary line.
   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((sbQueue.size() != 0 || busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout: got queue=%0d busy=%0b, expected queue=0 busy=0",
                  name, sbQueue.size(), busy);
      end
   endtask

   // Monitor: on every done pulse, compare against the oldest queued result.
   always @(negedge clock) begin
      if (!reset && done) begin
         checkOutput("done_single_cycle", {31'd0, prevDone}, 32'd0);
         if (sbQueue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no result pending");
         end else begin
            monExp = sbQueue.pop_front();
            checkOutput({monExp.name, "_mant"},    {8'd0, mant_out},     {8'd0, monExp.mant});
            checkOutput({monExp.name, "_count"},   {27'd0, shift_count}, {27'd0, monExp.count});
            checkOutput({monExp.name, "_sticky"},  {31'd0, sticky},      {31'd0, monExp.sticky});
            checkOutput({monExp.name, "_zero"},    {31'd0, zero},        {31'd0, monExp.zero});
            checkOutput({monExp.name, "_latency"}, cycle - monExp.acceptEdge, monExp.latency);
            checkOutput({monExp.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
         end
      end
      prevDone = done;
   end

   // Safety net in case the stimulus itself stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      mant_in  = '0;
      shamt_in = '0;

      // Outputs while reset is held.
      repeat (2) @(negedge clock);
      checkOutput("reset_mant",  {8'd0, mant_out},     32'd0);
      checkOutput("reset_count", {27'd0, shift_count}, 32'd0);
      checkOutput("reset_busy",  {31'd0, busy},        32'd0);
      checkOutput("reset_done",  {31'd0, done},        32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post_reset_zero", {31'd0, zero}, 32'd0);

      // Normalize 0x000123: 15 leading zeros.
      applyStimulus("norm_123", 1'b0, 24'h000123, 5'd0, 1'b1, 24'h918000, 5'd15, 1'b0, 1'b0, LatNorm123);
      waitIdle("norm_123");
      repeat (2) @(negedge clock);
      checkOutput("idle_hold_mant", {8'd0, mant_out}, 32'h918000);

      // Normalize a zero mantissa.
      applyStimulus("norm_zero", 1'b0, 24'h000000, 5'd0, 1'b1, 24'h000000, 5'd0, 1'b0, 1'b1, 1);
      waitIdle("norm_zero");

      // Align by 4, with a 1 shifted out into sticky.
      applyStimulus("align_4", 1'b1, 24'h800001, 5'd4, 1'b1, 24'h080000, 5'd4, 1'b1, 1'b0, 5);
      waitIdle("align_4");

      // Align by 0 leaves everything unchanged and clears sticky.
      applyStimulus("align_0", 1'b1, 24'hFFFFFF, 5'd0, 1'b1, 24'hFFFFFF, 5'd0, 1'b0, 1'b0, 1);
      waitIdle("align_0");

      // Align by 31. A start pulse in the middle must be ignored.
      applyStimulus("align_31", 1'b1, 24'hABCDEF, 5'd31, 1'b1, 24'h000000, 5'd31, 1'b1, 1'b1, 32);
      repeat (5) @(negedge clock);
      start   = 1'b1;
      mode    = 1'b0;
      mant_in = 24'h111111;
      @(negedge clock);
      start = 1'b0;
      waitIdle("align_31");

      // Reset in the middle of an align aborts it with no result.
      applyStimulus("align_reset", 1'b1, 24'h123456, 5'd20, 1'b0, 24'h0, 5'd0, 1'b0, 1'b0, 0);
      repeat (4) @(negedge clock);
      checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("async_reset_mant",   {8'd0, mant_out},     32'd0);
      checkOutput("async_reset_count",  {27'd0, shift_count}, 32'd0);
      checkOutput("async_reset_sticky", {31'd0, sticky},      32'd0);
      checkOutput("async_reset_busy",   {31'd0, busy},        32'd0);
      checkOutput("async_reset_done",   {31'd0, done},        32'd0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus("norm_400000", 1'b0, 24'h400000, 5'd0, 1'b1, 24'h800000, 5'd1, 1'b0, 1'b0, 2);
      waitIdle("norm_400000");

      // Back-to-back: hold start through the DONE cycle of a one-step normalize.
      // The second operation is align 0x000003 by 2.
      @(negedge clock);
      start    = 1'b1;
      mode     = 1'b0;
      mant_in  = 24'h800000;
      shamt_in = 5'd0;
      begin
         exp_t t;
         t.name = "b2b_first"; t.mant = 24'h800000; t.count = 5'd0;
         t.sticky = 1'b0; t.zero = 1'b0; t.latency = 1; t.acceptEdge = cycle + 1;
         sbQueue.push_back(t);
      end
      @(negedge clock);
      checkOutput("b2b_first_busy", {31'd0, busy}, 32'd1);
      mode     = 1'b1;
      mant_in  = 24'h000003;
      shamt_in = 5'd2;
      @(negedge clock);
      checkOutput("b2b_done_pulse", {31'd0, done}, 32'd1);
      checkOutput("b2b_done_busy",  {31'd0, busy}, 32'd0);
      begin
         exp_t t;
         t.name = "b2b_second"; t.mant = 24'h000000; t.count = 5'd2;
         t.sticky = 1'b1; t.zero = 1'b1; t.latency = 3; t.acceptEdge = cycle + 1;
         sbQueue.push_back(t);
      end
      @(negedge clock);
      start = 1'b0;
      checkOutput("b2b_second_busy", {31'd0, busy}, 32'd1);
      checkOutput("b2b_second_done", {31'd0, done}, 32'd0);
      waitIdle("b2b");

      repeat (3) @(negedge clock);
      checkOutput("scoreboard_empty", sbQueue.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
